life_sequencer: RTL and testbench
=================================

// Module: life_sequencer
// PURPOSE
//  Sequencer for the linear life_engine (GENS=1). Drives the engine RAM read/write addresses, we, sh, ld and init.
//  Runs whole-generation passes over a ping-pong RAM: read bank B, write bank !B, swap at end of pass.
//  Arbitrates the single RAM read port between video row fetches (priority) and the compute pass.
//  Handles host init writes of the initial pattern.
// PARAMETERS
//  ROWS    256  image rows per bank; engine DEPTH = 2*ROWS
//  RBITS   8    row address width, log2(ROWS); engine DBITS = RBITS+1
//  WR_DLY  4    cycles from a sh cycle to the we for that cycle's output row (matches engine pipeline)
//  GBITS   16   generation counter width
// PORTS
//  clk        in   1        clock
//  reset      in   1        synchronous, active-high
//  start      in   1        pulse: run one generation pass (ignored while busy or init)
//  run        in   1        level: start a new pass back-to-back while high
//  busy       out  1        pass in progress (read issue or write drain)
//  gen_done   out  1        1-cycle pulse at the bank swap
//  gen_count  out  GBITS    completed generations, wraps
//  disp_bank  out  1        bank holding the newest complete generation
//  vid_req    in   1        video row fetch request; held until vid_gnt
//  vid_row    in   RBITS    row to fetch, sampled on the grant cycle
//  vid_gnt    out  1        request accepted this cycle
//  vid_valid  out  1        engine dout holds the row, exactly 3 cycles after vid_gnt
//  init_en    in   1        host init mode; ignored while busy
//  init_wr    in   1        write init_data (at engine) to row init_row
//  init_row   in   RBITS    init row address
//  raddr      out  RBITS+1  engine read address {bank,row}
//  waddr      out  RBITS+1  engine write address {bank,row}
//  we         out  1        engine write enable
//  sh         out  1        engine shift/advance
//  ld         out  1        engine video load
//  init       out  1        engine init data select
// BEHAVIOUR
//  Reset: busy=0, gen_done=0, gen_count=0, disp_bank=0, vid_gnt=0, vid_valid=0, we=0, sh=0, ld=0, init=0.
//  Reset also clears raddr=0, waddr=0 and the delay line. Reset mid-pass aborts with no swap.
//  States: IDLE, INIT, PASS, DRAIN.
//  - IDLE->INIT on init_en. INIT->IDLE on !init_en.
//  - IDLE->PASS on start|run, with B = disp_bank and k = 0.
//  - PASS->DRAIN after read k = ROWS+1 issues.
//  - DRAIN->IDLE once the delay line is empty: swap disp_bank, gen_done=1, gen_count+1.
//  INIT: init=1; on init_wr, we=1 and waddr={disp_bank,init_row} in the same cycle. No reads; video is still served.
//  PASS read schedule: read index k = 0..ROWS+1 reads row (k-1) mod ROWS.
//  Sequence is ROWS-1, 0, 1, .., ROWS-1, 0 (vertical torus). Each read: raddr={B,row}, sh=1.
//  Arbitration per cycle: vid_req wins. Then vid_gnt=1, ld=1, raddr={disp_bank,vid_row}, sh=0, k holds.
//  Otherwise issue the next compute read.
//  Video is served in every state; vid_valid = vid_gnt delayed 3 cycles (2 RAM + 1 dout).
//  Write tracking: delay line of WR_DLY entries {v,row}, advancing every cycle.
//  - Push v = sh && k>=2, row = k-2.
//  - Output v -> we=1, waddr = {!B,row}.
//  - Exactly ROWS writes per pass, rows 0..ROWS-1 in order.
//  Stalls: a video grant drops sh, so the engine pipeline holds; the delay line carries v=0 for that cycle.
//  Simultaneous: start and init_en in IDLE -> init wins. start while busy ignored.
//  run deasserted mid-pass finishes the current pass.
//  No same-bank read/write hazard: computes read B, write !B; video reads disp_bank=B until the swap.
//  Row counters wrap modulo ROWS (ROWS is a power of two). gen_count wraps at 2^GBITS.
// STRUCTURE
//  Package life_pkg: typedef state_t {IDLE,INIT,PASS,DRAIN}; localparam VID_LAT=3; row/addr typedefs from RBITS.
//  Sub-module: life_wr_delay (WR_DLY-deep valid+row shift register), reused for the vid_valid delay.
// TESTING
//  start, no video, ROWS=8 -> reads rows 7,0..7,0; writes bank1 rows 0..7 in order.
//  For that run: 8 we pulses, gen_done once, disp_bank=1, gen_count=1.
//  vid_req held through a pass -> every cycle granted, sh=0, k frozen; vid_valid 3 cycles after each grant.
//  Pass then resumes and still yields 8 writes.
//  run=1 for 3 passes -> gen_count=3, disp_bank toggles 1,0,1; no idle cycle between DRAIN and next PASS.
//  reset asserted mid-PASS -> next cycle we=sh=busy=0, disp_bank=0, gen_count unchanged at 0; later start runs a full pass.
//  init_en with init_wr rows 0..7 -> we=1, init=1, waddr={0,row}; start in the same cycle as init_en is ignored.
//  Blinker on an 8x8 torus across row 7/0 -> after 1 pass the memory matches the golden model; after 2 passes it matches the original.

Source files
------------

// File: rtl/life_pkg.sv
// Shared types and constants for the life engine sequencer.
package life_pkg;

    localparam int VID_LAT   = 3;
    localparam int RBITS_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        INIT  = 2'd1,
        PASS  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    typedef logic [RBITS_DEF-1:0] row_t;
    typedef logic [RBITS_DEF:0]   addr_t;

endpackage

// File: rtl/life_wr_delay.sv
// Fixed-depth shift register of {valid,row} entries; advances every cycle.
module life_wr_delay #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_v,
    input  logic [W-1:0] in_row,
    output logic         out_v,
    output logic [W-1:0] out_row,
    output logic         any_v
);

    logic [DEPTH-1:0] v_r;
    logic [W-1:0]     row_r [DEPTH];

    // shift valid and row tags one stage per cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            v_r <= {DEPTH{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                row_r[i] <= {W{1'b0}};
            end
        end else begin
            v_r      <= {v_r[DEPTH-2:0], in_v};
            row_r[0] <= in_row;
            for (int i = 1; i < DEPTH; i++) begin
                row_r[i] <= row_r[i-1];
            end
        end
    end

    assign out_v   = v_r[DEPTH-1];
    assign out_row = row_r[DEPTH-1];
    assign any_v   = |v_r;

endmodule

// File: rtl/life_sequencer.sv
// Generation-pass sequencer for the linear life engine: ping-pong RAM banks,
// video read arbitration and host init writes.
module life_sequencer
    import life_pkg::*;
#(
    parameter int ROWS   = 256,
    parameter int RBITS  = 8,
    parameter int WR_DLY = 4,
    parameter int GBITS  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             run,
    output logic             busy,
    output logic             gen_done,
    output logic [GBITS-1:0] gen_count,
    output logic             disp_bank,
    input  logic             vid_req,
    input  logic [RBITS-1:0] vid_row,
    output logic             vid_gnt,
    output logic             vid_valid,
    input  logic             init_en,
    input  logic             init_wr,
    input  logic [RBITS-1:0] init_row,
    output logic [RBITS:0]   raddr,
    output logic [RBITS:0]   waddr,
    output logic             we,
    output logic             sh,
    output logic             ld,
    output logic             init
);

    localparam int               KBITS      = RBITS + 2;
    localparam logic [KBITS-1:0] K_ZERO     = KBITS'(0);
    localparam logic [KBITS-1:0] K_ONE      = KBITS'(1);
    localparam logic [KBITS-1:0] K_FIRST_WR = KBITS'(2);
    localparam logic [KBITS-1:0] K_LAST     = KBITS'(ROWS + 1);
    localparam logic [RBITS-1:0] ROW_ONE    = RBITS'(1);
    localparam logic [RBITS-1:0] ROW_TWO    = RBITS'(2);

    state_t           state_r, state_s;
    logic [KBITS-1:0] k_r, k_s;
    logic             disp_bank_r;
    logic [GBITS-1:0] gen_count_r;

    logic             sh_s, ld_s, we_s, init_s, gen_done_s;
    logic [RBITS:0]   raddr_s, waddr_s;

    logic             push_v_s;
    logic [RBITS-1:0] push_row_s;
    logic             wr_out_v_s;
    logic [RBITS-1:0] wr_out_row_s;
    logic             wr_any_s;

    logic             vid_valid_s;
    logic             vid_row_d_s;
    logic             vid_any_s;
    logic             vid_unused_s;

    // state, pass read index, display bank and generation counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            k_r         <= K_ZERO;
            disp_bank_r <= 1'b0;
            gen_count_r <= {GBITS{1'b0}};
        end else begin
            state_r <= state_s;
            k_r     <= k_s;
            if (gen_done_s) begin
                disp_bank_r <= ~disp_bank_r;
                gen_count_r <= gen_count_r + GBITS'(1);
            end else begin
                disp_bank_r <= disp_bank_r;
                gen_count_r <= gen_count_r;
            end
        end
    end

    // next state, read-port arbitration and write-port selection
    always_comb begin
        state_s    = state_r;
        k_s        = k_r;
        sh_s       = 1'b0;
        ld_s       = 1'b0;
        we_s       = 1'b0;
        init_s     = 1'b0;
        gen_done_s = 1'b0;
        raddr_s    = {(RBITS+1){1'b0}};
        waddr_s    = {(RBITS+1){1'b0}};

        // video always owns the read port when it asks; it reads the shown bank
        if (vid_req) begin
            ld_s    = 1'b1;
            raddr_s = {disp_bank_r, vid_row};
        end else begin
            ld_s    = 1'b0;
        end

        case (state_r)
            IDLE: begin
                if (init_en) begin
                    state_s = INIT;
                end else if (start || run) begin
                    state_s = PASS;
                    k_s     = K_ZERO;
                end else begin
                    state_s = IDLE;
                end
            end
            INIT: begin
                init_s = 1'b1;
                if (init_wr) begin
                    we_s    = 1'b1;
                    waddr_s = {disp_bank_r, init_row};
                end else begin
                    we_s    = 1'b0;
                end
                if (!init_en) begin
                    state_s = IDLE;
                end else begin
                    state_s = INIT;
                end
            end
            PASS: begin
                // index k reads row k-1, giving the torus order ROWS-1,0..ROWS-1,0
                if (!vid_req) begin
                    sh_s    = 1'b1;
                    raddr_s = {disp_bank_r, k_r[RBITS-1:0] - ROW_ONE};
                    k_s     = k_r + K_ONE;
                    if (k_r == K_LAST) begin
                        state_s = DRAIN;
                    end else begin
                        state_s = PASS;
                    end
                end else begin
                    sh_s = 1'b0;
                end
            end
            DRAIN: begin
                if (!wr_any_s) begin
                    gen_done_s = 1'b1;
                    if (run) begin
                        state_s = PASS;
                        k_s     = K_ZERO;
                    end else begin
                        state_s = IDLE;
                    end
                end else begin
                    state_s = DRAIN;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        // delayed compute writes go to the bank not being read
        if (wr_out_v_s) begin
            we_s    = 1'b1;
            waddr_s = {~disp_bank_r, wr_out_row_s};
        end else begin
            we_s    = we_s;
        end
    end

    // the engine emits an output row once it holds the rows above and below it
    assign push_v_s   = sh_s && (k_r >= K_FIRST_WR);
    assign push_row_s = k_r[RBITS-1:0] - ROW_TWO;

    life_wr_delay #(
        .DEPTH (WR_DLY),
        .W     (RBITS)
    ) u_wr_delay (
        .clk     (clk),
        .reset   (reset),
        .in_v    (push_v_s),
        .in_row  (push_row_s),
        .out_v   (wr_out_v_s),
        .out_row (wr_out_row_s),
        .any_v   (wr_any_s)
    );

    life_wr_delay #(
        .DEPTH (VID_LAT),
        .W     (1)
    ) u_vid_delay (
        .clk     (clk),
        .reset   (reset),
        .in_v    (vid_req),
        .in_row  (1'b0),
        .out_v   (vid_valid_s),
        .out_row (vid_row_d_s),
        .any_v   (vid_any_s)
    );

    assign vid_unused_s = vid_row_d_s ^ vid_any_s;

    assign busy      = (state_r == PASS) || (state_r == DRAIN);
    assign gen_done  = gen_done_s;
    assign gen_count = gen_count_r;
    assign disp_bank = disp_bank_r;
    assign vid_gnt   = vid_req;
    assign vid_valid = vid_valid_s;
    assign raddr     = raddr_s;
    assign waddr     = waddr_s;
    assign we        = we_s;
    assign sh        = sh_s;
    assign ld        = ld_s;
    assign init      = init_s;

endmodule

// File: tb/tb_life_sequencer.sv
// Randomized bench for life_sequencer on an 8x8 torus with a behavioural engine/RAM model.
module tb_life_sequencer;

    localparam int ROWS   = 8;
    localparam int RBITS  = 3;
    localparam int WR_DLY = 4;
    localparam int GBITS  = 16;

    logic             clk;
    logic             reset, start, run, init_en, init_wr;
    logic             vid_req;
    logic [RBITS-1:0] vid_row, init_row;
    logic             busy, gen_done, disp_bank, vid_gnt, vid_valid;
    logic             we, sh, ld, init;
    logic [GBITS-1:0] gen_count;
    logic [RBITS:0]   raddr, waddr;

    life_sequencer #(.ROWS(ROWS), .RBITS(RBITS), .WR_DLY(WR_DLY), .GBITS(GBITS)) dut (
        .clk(clk), .reset(reset), .start(start), .run(run), .busy(busy),
        .gen_done(gen_done), .gen_count(gen_count), .disp_bank(disp_bank),
        .vid_req(vid_req), .vid_row(vid_row), .vid_gnt(vid_gnt), .vid_valid(vid_valid),
        .init_en(init_en), .init_wr(init_wr), .init_row(init_row),
        .raddr(raddr), .waddr(waddr), .we(we), .sh(sh), .ld(ld), .init(init)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // one torus generation step for a single 8-cell row
    function automatic logic [7:0] life_row(input logic [7:0] up, input logic [7:0] mid, input logic [7:0] dn);
        logic [7:0] res;
        int n, l, r;
        res = 8'h00;
        for (int c = 0; c < 8; c++) begin
            l = (c + 7) % 8;
            r = (c + 1) % 8;
            n = int'(up[l]) + int'(up[c]) + int'(up[r]) + int'(mid[l]) + int'(mid[r])
              + int'(dn[l]) + int'(dn[c]) + int'(dn[r]);
            res[c] = (n == 3) || (mid[c] && (n == 2));
        end
        return res;
    endfunction

    logic [7:0] mem [16] = '{default: 8'h00};
    logic [7:0] snap [8];
    logic [7:0] pattern [8];
    logic [7:0] orig [8];

    function automatic logic [7:0] golden_row(input int r);
        return life_row(snap[(r + 7) % 8], snap[r], snap[(r + 1) % 8]);
    endfunction

    // reference model state
    int         rd_idx = 0, wr_idx = 0, nwin = 0, cyc = 0, last_we = -10, done_cnt = 0;
    logic [7:0] w0 = 8'h00, w1 = 8'h00, w2 = 8'h00;
    logic [7:0] rowq [$];
    logic [2:0] vid_hist = 3'b000;
    logic       exp_bank = 1'b0;
    int         exp_count = 0;
    logic       chk_busy = 1'b0;

    // per-cycle monitor: checks ports against the model and plays the engine and RAM
    always @(negedge clk) begin
        if (reset) begin
            rd_idx = 0; wr_idx = 0; nwin = 0; rowq.delete();
            vid_hist = 3'b000; exp_bank = 1'b0; exp_count = 0; chk_busy = 1'b0;
        end else begin
            if (chk_busy) check("no_idle_gap", 32'(busy), 32'd1);
            chk_busy = 1'b0;
            check("vid_valid", 32'(vid_valid), 32'(vid_hist[2]));
            vid_hist = {vid_hist[1:0], vid_req};
            check("vid_gnt", 32'(vid_gnt), 32'(vid_req));
            check("ld", 32'(ld), 32'(vid_req));
            if (vid_req) begin
                check("vid_sh", 32'(sh), 32'd0);
                check("vid_raddr", 32'(raddr), 32'({exp_bank, vid_row}));
            end
            if (sh) begin
                check("sh_busy", 32'(busy), 32'd1);
                check("rd_count", 32'(rd_idx < ROWS + 2), 32'd1);
                check("rd_addr", 32'(raddr), 32'({exp_bank, 3'((rd_idx + ROWS - 1) % ROWS)}));
                w0 = w1; w1 = w2; w2 = mem[raddr];
                if (nwin >= 2) rowq.push_back(life_row(w0, w1, w2));
                nwin++;
                rd_idx++;
            end
            if (init) begin
                check("init_we", 32'(we), 32'(init_wr));
                check("init_sh", 32'(sh), 32'd0);
                if (we) begin
                    check("init_waddr", 32'(waddr), 32'({exp_bank, init_row}));
                    mem[waddr] = pattern[init_row];
                end
            end else if (we) begin
                check("wr_addr", 32'(waddr), 32'({~exp_bank, 3'(wr_idx)}));
                check("wr_queue", 32'(rowq.size() > 0), 32'd1);
                if (rowq.size() > 0) mem[waddr] = rowq.pop_front();
                wr_idx++;
                last_we = cyc;
            end
            check("disp_bank", 32'(disp_bank), 32'(exp_bank));
            check("gen_count", 32'(gen_count), 32'(exp_count));
            if (gen_done) begin
                check("done_reads", 32'(rd_idx), 32'(ROWS + 2));
                check("done_writes", 32'(wr_idx), 32'(ROWS));
                check("done_timing", 32'(cyc - last_we), 32'd1);
                exp_bank = ~exp_bank;
                exp_count++;
                rd_idx = 0; wr_idx = 0; nwin = 0; rowq.delete();
                chk_busy = run;
                done_cnt++;
            end
        end
        cyc++;
    end

    // video requester: 0 idle, 1 random, 2 held
    int vid_mode = 0;
    initial begin
        vid_req = 1'b0;
        vid_row = 3'd0;
        forever begin
            @(posedge clk);
            #1;
            case (vid_mode)
                1:       vid_req = ($urandom_range(0, 3) == 0);
                2:       vid_req = 1'b1;
                default: vid_req = 1'b0;
            endcase
            vid_row = 3'($urandom);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int n);
        int target;
        target = done_cnt + n;
        for (int i = 0; i < 300 * n && done_cnt < target; i++) @(posedge clk);
        #1;
        check("pass_done", 32'(done_cnt >= target), 32'd1);
    endtask

    task automatic take_snap(input logic bank);
        for (int r = 0; r < ROWS; r++) snap[r] = mem[{bank, 3'(r)}];
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; run = 1'b0; init_en = 1'b0; init_wr = 1'b0; init_row = 3'd0;
        for (int r = 0; r < ROWS; r++) pattern[r] = 8'h00;
        pattern[7] = 8'h08; pattern[0] = 8'h08; pattern[1] = 8'h08;
        repeat (3) step();
        reset = 1'b0;
        step();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_gen_done", 32'(gen_done), 32'd0);
        check("rst_gen_count", 32'(gen_count), 32'd0);
        check("rst_disp_bank", 32'(disp_bank), 32'd0);
        check("rst_vid", 32'({vid_gnt, vid_valid, ld}), 32'd0);
        check("rst_engine", 32'({we, sh, init}), 32'd0);
        check("rst_addr", 32'({raddr, waddr}), 32'd0);

        // init wins over a simultaneous start
        vid_mode = 1;
        init_en = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        check("init_mode", 32'(init), 32'd1);
        check("init_start_ignored", 32'(busy), 32'd0);
        for (int r = 0; r < ROWS; r++) begin
            init_wr = 1'b1; init_row = 3'(r);
            step();
        end
        init_wr = 1'b0; init_en = 1'b0;
        step();
        step();
        check("init_exit", 32'({init, busy}), 32'd0);
        for (int r = 0; r < ROWS; r++) begin
            orig[r] = mem[{1'b0, 3'(r)}];
            check("init_row_data", 32'(orig[r]), 32'(pattern[r]));
        end

        // pass 1, no video: blinker flips to horizontal in bank 1
        vid_mode = 0;
        step();
        take_snap(1'b0);
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done(1);
        check("p1_gen_count", 32'(gen_count), 32'd1);
        check("p1_disp_bank", 32'(disp_bank), 32'd1);
        check("p1_blinker_row0", 32'(mem[4'b1000]), 32'h1C);
        for (int r = 0; r < ROWS; r++) check("p1_golden", 32'(mem[{1'b1, 3'(r)}]), 32'(golden_row(r)));

        // pass 2 with video held at first, then random; returns to the original
        vid_mode = 2;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (20) step();
        vid_mode = 1;
        wait_done(1);
        check("p2_gen_count", 32'(gen_count), 32'd2);
        check("p2_disp_bank", 32'(disp_bank), 32'd0);
        for (int r = 0; r < ROWS; r++) check("p2_orig", 32'(mem[{1'b0, 3'(r)}]), 32'(orig[r]));

        // run held for three back-to-back passes with random video
        run = 1'b1;
        wait_done(2);
        run = 1'b0;
        wait_done(1);
        check("run_gen_count", 32'(gen_count), 32'd5);
        check("run_disp_bank", 32'(disp_bank), 32'd1);
        vid_mode = 0;
        repeat (4) step();
        check("run_stopped", 32'(busy), 32'd0);

        // reset in the middle of a pass
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (5) step();
        check("pre_reset_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid_rst_engine", 32'({we, sh, busy}), 32'd0);
        check("mid_rst_gen_count", 32'(gen_count), 32'd0);
        check("mid_rst_disp_bank", 32'(disp_bank), 32'd0);
        step();
        take_snap(1'b0);
        vid_mode = 1;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done(1);
        check("post_rst_gen_count", 32'(gen_count), 32'd1);
        for (int r = 0; r < ROWS; r++) check("post_rst_golden", 32'(mem[{1'b1, 3'(r)}]), 32'(golden_row(r)));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
